// File: rtl/regfile_dump.sv
// Sequential dumper for the LC-3 register file: walks the SR1 read select over
// R0..R(NUM_REGS-1) and streams each captured word with its index on a valid/ready port.
module regfile_dump #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  output logic [IDX_W-1:0] Rd_Sel,
  input  logic [15:0]      Rd_Data,
  output logic [15:0]      Out_Data,
  output logic [IDX_W-1:0] Out_Idx,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Dbg_State
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SEND    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             capture;
  logic             handshake;

  // Stream handshake: a word transfers on a rising Clk edge where Out_Valid and
  // Out_Ready are both high. Once raised, Out_Valid stays high and Out_Data/Out_Idx
  // stay stable until that transfer; Out_Ready may toggle freely.
  assign handshake = (state == S_SEND) && Out_Ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        idx_nxt = '0;
        if (Start) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture   = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (Out_Ready) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = S_CAPTURE;
          end
        end
      end
      S_DONE: begin
        idx_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        idx_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The word reflects the file as read during CAPTURE; a write landing on this
  // same edge is not visible here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out_Data  <= 16'h0000;
      Out_Idx   <= '0;
      Out_Valid <= 1'b0;
    end else begin
      if (capture) begin
        Out_Data  <= Rd_Data;
        Out_Idx   <= idx;
        Out_Valid <= 1'b1;
      end else if (handshake) begin
        Out_Valid <= 1'b0;
      end
    end
  end

  assign Rd_Sel    = idx;
  assign Busy      = (state == S_CAPTURE) || (state == S_SEND);
  assign Done      = (state == S_DONE);
  assign Dbg_State = state;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a small register-file model feeds Rd_Data, and every
// accepted word is compared with an expected queue built from the register contents.
module tb_regfile_dump;

  localparam int W = 19;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Rd_Sel;
  logic [15:0] Rd_Data;
  logic [15:0] Out_Data;
  logic [2:0]  Out_Idx;
  logic        Out_Valid;
  logic        Out_Ready = 1'b0;
  logic        Busy;
  logic        Done;
  logic [1:0]  Dbg_State;

  logic [15:0] rf [8];
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] load_vals [8];

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  regfile_dump #(.NUM_REGS(8), .IDX_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Rd_Sel(Rd_Sel), .Rd_Data(Rd_Data),
    .Out_Data(Out_Data), .Out_Idx(Out_Idx), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Busy(Busy), .Done(Done), .Dbg_State(Dbg_State)
  );

  // clock / register-file model
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end
  assign Rd_Data = rf[Rd_Sel];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic load_regs();
    for (int k = 0; k < 8; k++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(k);
      wr_data = load_vals[k];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic random_vals();
    for (int k = 0; k < 8; k++) load_vals[k] = 16'($urandom_range(0, 65535));
  endtask

  task automatic fill_exp();
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back({3'(k), load_vals[k]});
  endtask

  // One complete dump: pulses Start, then consumes words with the given ready
  // probability, checking each offered word against the head of exp_q.
  task automatic do_dump(input int ready_pct, input int bp_word, input int bp_len,
                         input bit poke, input bit strict_timing, input bit wr_test);
    int c, words, dones, busy_cyc, bp_left, done_cyc;
    bit hs;
    words = 0; dones = 0; busy_cyc = 0; done_cyc = 0; bp_left = bp_len;
    Start = 1'b1;
    tick();
    c = 1;
    while (1) begin
      Start = 1'b0;
      wr_en = 1'b0;
      if (c > 400) begin
        check("dump_timeout", dones, 1);
        break;
      end
      if (Done) begin
        dones++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (Busy) busy_cyc++;
      if (Out_Valid) begin
        if (exp_q.size() == 0) check("extra_word", exp_q.size(), 1);
        else check("word", {Out_Idx, Out_Data}, exp_q[0]);
      end
      if (Busy && exp_q.size() > 0) check("rd_sel", Rd_Sel, exp_q[0][18:16]);
      if (strict_timing) begin
        check("t_valid", Out_Valid, (c >= 2 && c <= 16 && c % 2 == 0));
        check("t_busy", Busy, (c >= 1 && c <= 16));
        check("t_done", Done, (c == 17));
      end
      if (done_cyc != 0 && c == done_cyc + 1) begin
        check("idle_after_done", {Busy, Out_Valid, Done}, 0);
        break;
      end
      if (poke && (Done || (Out_Valid && Out_Idx == 3'd4))) Start = 1'b1;
      if (Out_Valid && Out_Idx == 3'(bp_word) && bp_left > 0) begin
        Out_Ready = 1'b0;
        bp_left--;
      end else begin
        Out_Ready = ($urandom_range(0, 99) < ready_pct);
      end
      if (wr_test && c == 11) begin
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
      end
      if (wr_test && c == 12) begin
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'hCAFE;
      end
      hs = Out_Valid && Out_Ready;
      if (hs) words++;
      tick();
      if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
      c++;
    end
    Out_Ready = 1'b0;
    Start = 1'b0;
    wr_en = 1'b0;
    check("word_count", words, 8);
    check("done_count", dones, 1);
    check("exp_left", exp_q.size(), 0);
    if (strict_timing) check("busy_cycles", busy_cyc, 16);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, Out_Valid, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_data"}, Out_Data, 16'h0000);
    check({tag, "_idx"}, Out_Idx, 0);
    check({tag, "_rdsel"}, Rd_Sel, 0);
  endtask

  // directed sequence + final report
  initial begin
    int seen;
    bit hit;
    #1;
    tick();
    tick();
    check_reset_vals("rst");
    check("rst_state", Dbg_State, 0);
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Out_Valid || Busy || Done) seen++;
    end
    check("idle_no_activity", seen, 0);

    for (int k = 0; k < 8; k++) load_vals[k] = 16'h1000 + 16'(k);
    load_regs();
    fill_exp();
    do_dump(100, -1, 0, 1'b0, 1'b1, 1'b0);

    random_vals();
    load_regs();
    fill_exp();
    do_dump(100, 3, 5, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) load_vals[k] = 16'h1000 + 16'(k);
    load_regs();
    fill_exp();
    do_dump(60, 3, 5, 1'b0, 1'b0, 1'b0);

    random_vals();
    load_regs();
    fill_exp();
    do_dump(70, -1, 0, 1'b1, 1'b0, 1'b0);

    // R5 written on its own capture edge keeps the old value; R6 written earlier is seen
    random_vals();
    load_regs();
    fill_exp();
    exp_q[6] = {3'd6, 16'hCAFE};
    do_dump(100, -1, 0, 1'b0, 1'b1, 1'b1);

    random_vals();
    load_regs();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (Out_Valid && Out_Idx == 3'd2) begin
        hit = 1'b1;
        Out_Ready = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_reset_vals("midrst");
      end else begin
        Out_Ready = 1'b1;
        tick();
      end
    end
    Out_Ready = 1'b0;
    check("midrst_reached", hit, 1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Done || Busy) seen++;
    end
    check("midrst_quiet", seen, 0);
    fill_exp();
    do_dump(80, -1, 0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      random_vals();
      load_regs();
      fill_exp();
      do_dump(int'($urandom_range(30, 90)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 4)), 1'b1, 1'b0, 1'b0);
    end

    Reset = 1'b1;
    Start = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    check("rst_beats_start_busy", Busy, 0);
    check("rst_beats_start_valid", Out_Valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential reader for the LC-3 eight-entry register file. On a Start pulse it walks the file's SR1 read-select through R0..R7, captures each word and presents it on a valid/ready output stream together with its register index, for the hex-display/debug path. It owns the SR1 select only while Busy; the top-level mux returns SR1 select to the datapath when Busy is low.

## Interface
- NUM_REGS, 8, number of registers dumped, indices 0..NUM_REGS-1
- IDX_W, 3, width of register index; NUM_REGS <= 2**IDX_W
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- Start  in  1  request a dump; sampled only in IDLE
- Rd_Sel  out  IDX_W  register select driven to file SR1 read port
- Rd_Data  in  16  combinational SR1 read data for Rd_Sel
- Out_Data  out  16  captured register value
- Out_Idx  out  IDX_W  index of the register in Out_Data
- Out_Valid  out  1  Out_Data/Out_Idx valid
- Out_Ready  in  1  consumer accepts the word when high with Out_Valid
- Busy  out  1  dump in progress (CAPTURE or SEND)
- Done  out  1  one-cycle pulse after the last word is accepted

## Operation
- Reset is Reset, synchronous, active-high; clock is Clk.
- States: IDLE, CAPTURE, SEND, DONE. Index register idx (IDX_W bits).
- IDLE: idx=0, Out_Valid=0. Start=1 -> CAPTURE. Start=0 -> stay.
- CAPTURE (exactly 1 cycle): Rd_Sel=idx; at the edge, Out_Data<=Rd_Data, Out_Idx<=idx, Out_Valid<=1; -> SEND.
- SEND: Out_Valid=1, Out_Data/Out_Idx held stable. Out_Ready=0 -> stay. Out_Ready=1 (handshake): Out_Valid<=0; if idx==NUM_REGS-1 -> DONE, idx<=0; else idx<=idx+1 -> CAPTURE.
- DONE (1 cycle): Done=1, Busy=0; -> IDLE unconditionally. Start in DONE is ignored.
- Rd_Sel = idx in all states (0 in IDLE/DONE).
- Busy = (state==CAPTURE or SEND), combinational from state.
- Start while Busy or in DONE: ignored, no queuing.
- Each word reflects the register contents during its CAPTURE cycle; a datapath write completing at the CAPTURE edge is not seen (file updates on the same edge). No cross-word atomicity.
- idx never exceeds NUM_REGS-1; no wrap past the last register.

## Timing
- Reset values: Rd_Sel=0, Out_Data=16'h0000, Out_Idx=0, Out_Valid=0, Busy=0, Done=0; state IDLE.
- Start high at edge E0 -> CAPTURE in cycle after E0 (Busy=1) -> Out_Valid=1 after E1.
- Per word: 1 CAPTURE cycle + >=1 SEND cycle. With Out_Ready tied high: full dump = 2*NUM_REGS cycles Busy (16), Done in cycle 17 after E0, IDLE in cycle 18; earliest re-Start sampled in IDLE.
- Out_Valid never deasserts without a handshake; Out_Data/Out_Idx change only at CAPTURE edges.
- Reset mid-dump: next edge forces all reset values; Out_Valid drops that cycle, no Done pulse, in-flight word discarded.
- Reset and Start same cycle: Reset wins.

## Test plan
- Reset: after Reset high one edge, all outputs at reset values; Start held low -> no Out_Valid for 20 cycles.
- Full dump, Ready=1: R0..R7 preloaded 16'h1000+k -> words (k, 16'h1000+k) in order k=0..7, Out_Valid high cycles 2,4,..,16 after Start, Done single pulse cycle 17, Busy high exactly 16 cycles.
- Backpressure: Out_Ready low 5 cycles on word 3 -> Out_Data=16'h1003, Out_Idx=3 held stable, Rd_Sel=3 held, then resumes; 8 words total, no duplicates.
- Start while Busy (pulse at word 4) and during DONE -> ignored; exactly 8 words, one Done.
- Write during dump: write R5<=16'hBEEF at R5's CAPTURE edge -> word 5 = old value; write at R6's CAPTURE edge from earlier cycle -> word 6 = new value.
- Reset mid-dump at word 2 SEND -> Out_Valid=0 next cycle, no Done; new Start yields full 8-word dump from R0.
